// File: rtl/ice40_ebr_sdp_pkg.sv
// ice40_ebr_sdp_pkg: EBR geometry constants and configuration legality check
package ice40_ebr_pkg;
  localparam int EBR_BITS = 4096;
  localparam int EBR_WIDTHS [4] = '{2, 4, 8, 16};
  function automatic bit ebr_cfg_ok(int data_width, int addr_width);
    bit w_ok = 1'b0;
    foreach (EBR_WIDTHS[i]) w_ok |= (EBR_WIDTHS[i] == data_width);
    return w_ok && addr_width > 0 && addr_width < 16 && data_width * (1 << addr_width) <= EBR_BITS;
  endfunction
endpackage

// File: rtl/ice40_ebr_sdp_if.sv
// ice40_ebr_sdp_if: write/read bus of the EBR (din, write_en, waddr, raddr -> dout)
interface ice40_ebr_sdp_if #(
  parameter int data_width = 16,
  parameter int addr_width = 8
);
  logic [data_width-1:0] din;
  logic                  write_en;
  logic [addr_width-1:0] waddr;
  logic [addr_width-1:0] raddr;
  logic [data_width-1:0] dout;
  modport master (output din, write_en, waddr, raddr, input dout);
  modport slave (input din, write_en, waddr, raddr, output dout);
endinterface

// File: rtl/ice40_ebr_sdp.sv
// ice40_ebr_sdp: single-clock simple-dual-port RAM for one iCE40 4 Kbit EBR
// ports: clock, reset (sync, active-high); bus.slave carries din/write_en/waddr (write), raddr/dout (registered read)
module ice40_ebr_sdp
  import ice40_ebr_pkg::*;
#(
  parameter int data_width = 16,
  parameter int addr_width = 8
) (
  input  logic            clock,
  input  logic            reset,
  ice40_ebr_sdp_if.slave  bus
);
  if (!ebr_cfg_ok(data_width, addr_width)) begin : g_bad_cfg
    $fatal(1, "ice40_ebr_sdp: illegal data_width/addr_width for one EBR");
  end
  logic [data_width-1:0] mem [2**addr_width] = '{default: '0};
  always_ff @(posedge clock)
    if (bus.write_en && !reset) mem[bus.waddr] <= bus.din;
  // separate read process keeps read-before-write on a same-address collision
  always_ff @(posedge clock)
    bus.dout <= reset ? '0 : mem[bus.raddr];
endmodule

// File: tb/tb_ice40_ebr_sdp.sv
module tb_ice40_ebr_sdp;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  ice40_ebr_sdp_if #(.data_width(16), .addr_width(8)) bus ();
  ice40_ebr_sdp_if #(.data_width(8), .addr_width(9)) bus8 ();
  ice40_ebr_sdp #(.data_width(16), .addr_width(8)) dut (.clock(clock), .reset(reset), .bus(bus));
  ice40_ebr_sdp #(.data_width(8), .addr_width(9)) dut8 (.clock(clock), .reset(reset), .bus(bus8));
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    {bus.din, bus.write_en, bus.waddr, bus.raddr} = '0;
    {bus8.din, bus8.write_en, bus8.waddr, bus8.raddr} = '0;
    repeat (3) begin
      step();
      chk("reset_dout", bus.dout, 16'h0000);
    end
    reset = 1'b0;
    step();
    chk("powerup_zero", bus.dout, 16'h0000);
  endtask
  task automatic test_latency();
    bus.write_en = 1'b1; bus.waddr = 8'd5; bus.din = 16'hA5A5; bus.raddr = 8'd0;
    step();
    bus.write_en = 1'b0; bus.raddr = 8'd5;
    chk("latency_before_edge", bus.dout, 16'h0000);
    step();
    chk("latency_after_edge", bus.dout, 16'hA5A5);
  endtask
  task automatic test_rbw();
    bus.write_en = 1'b1; bus.waddr = 8'd7; bus.din = 16'h1111; bus.raddr = 8'd0;
    step();
    bus.din = 16'h2222; bus.raddr = 8'd7;
    step();
    chk("rbw_old", bus.dout, 16'h1111);
    bus.write_en = 1'b0;
    step();
    chk("rbw_new", bus.dout, 16'h2222);
  endtask
  task automatic test_sweep();
    for (int i = 0; i < 256; i++) begin
      bus.write_en = 1'b1; bus.waddr = 8'(i); bus.din = 16'(i * 3 + 1);
      step();
      bus.write_en = 1'b0; bus.waddr = 8'(i + 1); bus.din = 16'hFFFF;
      step();
    end
    bus.raddr = 8'd0;
    for (int i = 0; i < 256; i++) begin
      bus.raddr = 8'(i);
      step();
      chk($sformatf("sweep[%0d]", i), bus.dout, 16'(i * 3 + 1));
    end
  endtask
  task automatic test_independent();
    bus.write_en = 1'b1; bus.waddr = 8'd20; bus.din = 16'h1234; bus.raddr = 8'd21;
    step();
    chk("indep_read21", bus.dout, 16'h0040);
    bus.write_en = 1'b0; bus.raddr = 8'd20;
    step();
    chk("indep_read20", bus.dout, 16'h1234);
  endtask
  task automatic test_reset_mid();
    bus.write_en = 1'b1; bus.waddr = 8'd9; bus.din = 16'hBEEF; bus.raddr = 8'd20;
    step();
    reset = 1'b1; bus.din = 16'h0000; bus.raddr = 8'd9;
    step();
    chk("mid_reset_dout0", bus.dout, 16'h0000);
    step();
    chk("mid_reset_dout1", bus.dout, 16'h0000);
    reset = 1'b0; bus.write_en = 1'b0;
    step();
    chk("mid_reset_kept", bus.dout, 16'hBEEF);
    bus.raddr = 8'd20;
    step();
    chk("mid_reset_other", bus.dout, 16'h1234);
  endtask
  task automatic test_variant();
    bus8.write_en = 1'b1; bus8.waddr = 9'd511; bus8.din = 8'hFF; bus8.raddr = 9'd0;
    step();
    bus8.waddr = 9'd0; bus8.din = 8'h01; bus8.raddr = 9'd511;
    step();
    chk("w8_read511", {8'h00, bus8.dout}, 16'h00FF);
    bus8.write_en = 1'b0; bus8.raddr = 9'd0;
    step();
    chk("w8_read0", {8'h00, bus8.dout}, 16'h0001);
    bus8.raddr = 9'd256;
    step();
    chk("w8_read256", {8'h00, bus8.dout}, 16'h0000);
  endtask
  initial begin
    test_reset();
    test_latency();
    test_rbw();
    test_sweep();
    test_independent();
    test_reset_mid();
    test_variant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
